// File: rtl/single_macc_datapath.sv
// rtl/single_macc_datapath.sv - pipelined multiply-accumulate with rounding and a valid/ready hold register
// Optional output clamp enabled by defining SINGLE_MACC_SATURATE_EN.
module single_macc_datapath #(
  parameter int DataWidth  = 16,
  parameter int CoeffWidth = 16,
  parameter int AccGuard   = 4,
  parameter int OutShift   = 15,
  parameter int OutWidth   = 16
) (
  input  logic                  Clk_i,
  input  logic                  Rst_i,
  input  logic [DataWidth-1:0]  Data_i,
  input  logic [CoeffWidth-1:0] Coeff_i,
  input  logic                  StartAcc_i,
  input  logic                  DataValid_i,
  output logic [OutWidth-1:0]   Result_o,
  output logic                  ResultValid_o,
  input  logic                  Ready_i,
  output logic                  Overrun_o
);

  localparam int ProdWidth = DataWidth + CoeffWidth;
  localparam int AccWidth  = ProdWidth + AccGuard;
  localparam logic signed [AccWidth-1:0] RoundBias = AccWidth'(1) << (OutShift - 1);

  logic signed [DataWidth-1:0]  dataQ1;
  logic signed [CoeffWidth-1:0] coeffQ1;
  logic                         startQ1;
  logic                         lastQ1;
  logic signed [ProdWidth-1:0]  prodFull;
  logic signed [AccWidth-1:0]   prodQ2;
  logic                         startQ2;
  logic                         lastQ2;
  logic signed [AccWidth-1:0]   accQ3;
  logic                         lastQ3;
  logic signed [AccWidth-1:0]   roundSum;
  logic signed [AccWidth-1:0]   rounded;
  logic [OutWidth-1:0]          nextResult;

  assign prodFull = dataQ1 * coeffQ1;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      dataQ1  <= '0;
      coeffQ1 <= '0;
      startQ1 <= 1'b0;
      lastQ1  <= 1'b0;
      prodQ2  <= '0;
      startQ2 <= 1'b0;
      lastQ2  <= 1'b0;
      accQ3   <= '0;
      lastQ3  <= 1'b0;
    end else begin
      dataQ1  <= Data_i;
      coeffQ1 <= Coeff_i;
      startQ1 <= StartAcc_i;
      lastQ1  <= DataValid_i;
      prodQ2  <= {{AccGuard{prodFull[ProdWidth-1]}}, prodFull};
      startQ2 <= startQ1;
      lastQ2  <= lastQ1;
      // A start tap restarts the sum so back-to-back frames need no idle cycle.
      accQ3   <= startQ2 ? prodQ2 : accQ3 + prodQ2;
      lastQ3  <= lastQ2;
    end
  end

  assign roundSum = accQ3 + RoundBias;
  assign rounded  = roundSum >>> OutShift;

`ifdef SINGLE_MACC_SATURATE_EN
  localparam logic signed [AccWidth-1:0] OutMax = (AccWidth'(1) << (OutWidth - 1)) - AccWidth'(1);
  localparam logic signed [AccWidth-1:0] OutMin = -(AccWidth'(1) << (OutWidth - 1));

  always_comb begin
    nextResult = rounded[OutWidth-1:0];
    if (rounded > OutMax) begin
      nextResult = OutMax[OutWidth-1:0];
    end else if (rounded < OutMin) begin
      nextResult = OutMin[OutWidth-1:0];
    end
  end
`else
  logic unusedRoundBits;

  assign nextResult      = rounded[OutWidth-1:0];
  assign unusedRoundBits = ^rounded[AccWidth-1:OutWidth];
`endif

  // A new result may replace a held one only on the cycle it is accepted.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      Result_o      <= '0;
      ResultValid_o <= 1'b0;
      Overrun_o     <= 1'b0;
    end else if (lastQ3) begin
      if (!ResultValid_o || Ready_i) begin
        Result_o      <= nextResult;
        ResultValid_o <= 1'b1;
      end else begin
        Overrun_o <= 1'b1;
      end
    end else if (Ready_i) begin
      ResultValid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_single_macc_datapath.sv
// tb/tb_single_macc_datapath.sv - directed and randomized frames checked against a dot-product model
module tb_single_macc_datapath;

  logic        Clk_i = 1'b0;
  logic        Rst_i;
  logic [15:0] Data_i;
  logic [15:0] Coeff_i;
  logic        StartAcc_i;
  logic        DataValid_i;
  logic [15:0] Result_o;
  logic        ResultValid_o;
  logic        Ready_i;
  logic        Overrun_o;

  always #5 Clk_i = ~Clk_i;

  single_macc_datapath dut (
    .Clk_i         (Clk_i),
    .Rst_i         (Rst_i),
    .Data_i        (Data_i),
    .Coeff_i       (Coeff_i),
    .StartAcc_i    (StartAcc_i),
    .DataValid_i   (DataValid_i),
    .Result_o      (Result_o),
    .ResultValid_o (ResultValid_o),
    .Ready_i       (Ready_i),
    .Overrun_o     (Overrun_o)
  );

  int passCnt = 0;
  int failCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  bit autoCheck = 1'b0;
  int expCycQ[$];
  logic [15:0] expValQ[$];
  logic signed [15:0] tapD[16];
  logic signed [15:0] tapC[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Rounded (and optionally clamped) output for an exact dot-product sum.
  function automatic logic [15:0] model(input longint sum);
    longint r;
    r = (sum + 64'sd16384) >>> 15;
`ifdef SINGLE_MACC_SATURATE_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic stepCycle();
    @(posedge Clk_i);
    #1;
    cyc++;
    if (autoCheck) begin
      if (expCycQ.size() > 0 && expCycQ[0] == cyc) begin
        check("valid_at_latency", {31'd0, ResultValid_o}, 32'd1);
        check("result", {16'd0, Result_o}, {16'd0, expValQ[0]});
        void'(expCycQ.pop_front());
        void'(expValQ.pop_front());
      end else begin
        check("valid_idle", {31'd0, ResultValid_o}, 32'd0);
      end
    end
  endtask

  task automatic driveFrame(input int n);
    longint sum = 0;
    for (int i = 0; i < n; i++) begin
      Data_i      = tapD[i];
      Coeff_i     = tapC[i];
      StartAcc_i  = (i == 0);
      DataValid_i = (i == n - 1);
      sum += longint'(tapD[i]) * longint'(tapC[i]);
      if (i == n - 1) begin
        expCycQ.push_back(cyc + 4);
        expValQ.push_back(model(sum));
      end
      stepCycle();
    end
    StartAcc_i  = 1'b0;
    DataValid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    StartAcc_i  = 1'b0;
    DataValid_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      Data_i  = 16'($urandom);
      Coeff_i = 16'($urandom);
      stepCycle();
    end
  endtask

  task automatic fillTaps(input int n, input logic signed [15:0] d, input logic signed [15:0] c);
    for (int i = 0; i < n; i++) begin
      tapD[i] = d;
      tapC[i] = c;
    end
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) begin
      tapD[i] = 16'($urandom);
      tapC[i] = 16'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kA;
    logic [15:0] expA;
    Rst_i = 1'b1;
    Data_i = '0;
    Coeff_i = '0;
    StartAcc_i = 1'b0;
    DataValid_i = 1'b0;
    Ready_i = 1'b1;
    stepCycle();
    stepCycle();
    check("reset_result", {16'd0, Result_o}, 32'd0);
    check("reset_valid", {31'd0, ResultValid_o}, 32'd0);
    check("reset_overrun", {31'd0, Overrun_o}, 32'd0);
    Rst_i = 1'b0;
    idle(2);
    autoCheck = 1'b1;

    // Reset two cycles mid-frame, with a completed one-tap frame still in flight.
    Data_i = 16'd5; Coeff_i = 16'h4000; StartAcc_i = 1'b1; DataValid_i = 1'b1;
    stepCycle();
    Data_i = 16'd9; StartAcc_i = 1'b1; DataValid_i = 1'b0;
    stepCycle();
    StartAcc_i = 1'b0;
    Rst_i = 1'b1;
    stepCycle();
    stepCycle();
    Rst_i = 1'b0;
    check("midreset_result", {16'd0, Result_o}, 32'd0);
    check("midreset_valid", {31'd0, ResultValid_o}, 32'd0);
    check("midreset_overrun", {31'd0, Overrun_o}, 32'd0);
    idle(8);

    fillTaps(16, 16'sd1, 16'sh4000);
    driveFrame(16);
    idle(6);

    fillTaps(1, 16'sd1, 16'sh4000);
    driveFrame(1);
    fillTaps(1, -16'sd1, 16'sh4000);
    driveFrame(1);
    fillTaps(1, 16'sd3, 16'sh2000);
    driveFrame(1);
    idle(6);

    fillTaps(16, 16'sh7FFF, 16'sh7FFF);
    driveFrame(16);
    idle(6);

    fillTaps(16, -16'sh8000, -16'sh8000);
    driveFrame(16);
    idle(6);

    fillRandom(4);
    driveFrame(4);
    fillRandom(4);
    driveFrame(4);
    idle(6);

    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, 16);
      fillRandom(n);
      driveFrame(n);
      idle($urandom_range(0, 2));
    end
    idle(6);
    check("queue_drained", expCycQ.size(), 32'd0);

    // Backpressure: first result held, second dropped.
    autoCheck = 1'b0;
    Ready_i = 1'b0;
    kA = cyc;
    expA = model(longint'(16'sd7) * longint'(16'sh4000));
    Data_i = 16'd7; Coeff_i = 16'h4000; StartAcc_i = 1'b1; DataValid_i = 1'b1;
    stepCycle();
    StartAcc_i = 1'b0; DataValid_i = 1'b0;
    stepCycle();
    Data_i = 16'd100; Coeff_i = 16'h4000; StartAcc_i = 1'b1; DataValid_i = 1'b1;
    stepCycle();
    StartAcc_i = 1'b0; DataValid_i = 1'b0;
    while (cyc < kA + 4) stepCycle();
    check("bp_first_valid", {31'd0, ResultValid_o}, 32'd1);
    check("bp_first_result", {16'd0, Result_o}, {16'd0, expA});
    check("bp_no_overrun_yet", {31'd0, Overrun_o}, 32'd0);
    stepCycle();
    stepCycle();
    check("bp_held_valid", {31'd0, ResultValid_o}, 32'd1);
    check("bp_held_result", {16'd0, Result_o}, {16'd0, expA});
    check("bp_overrun_set", {31'd0, Overrun_o}, 32'd1);
    Ready_i = 1'b1;
    stepCycle();
    check("bp_accept_valid", {31'd0, ResultValid_o}, 32'd0);
    check("bp_overrun_sticky", {31'd0, Overrun_o}, 32'd1);
    idle(3);
    check("bp_idle_valid", {31'd0, ResultValid_o}, 32'd0);
    check("bp_idle_overrun", {31'd0, Overrun_o}, 32'd1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
